// File: rtl/round_credit_sink.sv
// round_credit_sink: credit-managed FWFT FIFO at the tail of the round pipeline.
// Credits cover blocks in flight plus blocks buffered, so an arriving block always has a slot.
module round_credit_sink #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       issue_i,
  output logic                       issue_ok,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           round_in,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] reserved,
  output logic                       err_issue,
  output logic                       err_overflow
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    r_reserved;
  logic             r_err_issue;
  logic             r_err_overflow;
  logic             w_full;
  logic             w_pop;
  logic             w_issue_acc;
  logic             w_write;
  logic             w_overflow;
  assign w_full      = r_level == FULL;
  assign issue_ok    = r_reserved < FULL;
  assign out_valid   = r_level != '0;
  assign out_data    = r_mem[r_rd_ptr];
  assign w_pop       = out_valid & out_ready;
  assign w_issue_acc = issue_i & issue_ok;
  // a pop in the same cycle frees the slot, so a write at full is still accepted
  assign w_write     = valid_i & (~w_full | w_pop);
  assign w_overflow  = valid_i & w_full & ~w_pop;
  assign level       = r_level;
  assign reserved    = r_reserved;
  assign err_issue   = r_err_issue;
  assign err_overflow = r_err_overflow;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_reserved     <= '0;
      r_err_issue    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wr_ptr       <= r_wr_ptr + PW'(w_write);
      r_rd_ptr       <= r_rd_ptr + PW'(w_pop);
      r_level        <= r_level + LW'(w_write) - LW'(w_pop);
      r_reserved     <= r_reserved + LW'(w_issue_acc) - LW'(w_pop);
      r_err_issue    <= r_err_issue | (issue_i & ~issue_ok);
      r_err_overflow <= r_err_overflow | w_overflow;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && w_write) r_mem[r_wr_ptr] <= round_in;
  end
endmodule
